// File: rtl/frame_info_pkg.sv
`default_nettype none
// ============================================================================
// Module   : frame_info_pkg
// Brief    : Shared types and constants for the frame info double-buffer.
// Revision : 1.0  initial release
// ============================================================================
package frame_info_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_MAP   = 2'd0;
    localparam logic [1:0] ADDR_KIRBY = 2'd1;
    localparam logic [1:0] ADDR_CTRL  = 2'd2;
    localparam logic [1:0] ADDR_RSVD  = 2'd3;

    localparam int unsigned CTRL_ARM_BIT    = 0;
    localparam int unsigned CTRL_CANCEL_BIT = 1;

    localparam int unsigned MAP_IDX_MSB  = 17;
    localparam int unsigned MAP_IDX_LSB  = 16;
    localparam int unsigned MAP_IMGX_LSB = 8;
    localparam int unsigned MAP_IMGY_LSB = 0;

    localparam int unsigned KIRBY_POSX_LSB = 24;
    localparam int unsigned KIRBY_POSY_LSB = 16;
    localparam int unsigned KIRBY_IMGX_LSB = 8;
    localparam int unsigned KIRBY_IMGY_LSB = 0;

    // Bits above the map index are unused and always stored as zero.
    localparam logic [31:0] MAP_WORD_MASK = (32'd1 << (MAP_IDX_MSB + 1)) - 32'd1;

endpackage : frame_info_pkg
`default_nettype wire

// File: rtl/vs_edge_sync.sv
`default_nettype none
// ============================================================================
// Module   : vs_edge_sync
// Brief    : Two-flop synchronizer for VGA_VS plus registered falling-edge pulse.
// Revision : 1.0  initial release
// ============================================================================
module vs_edge_sync (
    input  logic Clk,
    input  logic Reset,
    input  logic i_vs_n,
    output logic o_vs_fall
);

    logic r_sync1;
    logic r_sync2;
    logic r_sync_hist;
    logic r_vs_fall;

    // Flops idle high so that leaving reset never fakes a falling edge.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_sync_hist <= 1'b1;
            r_vs_fall   <= 1'b0;
        end else begin
            r_sync1     <= i_vs_n;
            r_sync2     <= r_sync1;
            r_sync_hist <= r_sync2;
            r_vs_fall   <= r_sync_hist & ~r_sync2;
        end
    end

    assign o_vs_fall = r_vs_fall;

endmodule : vs_edge_sync
`default_nettype wire

// File: rtl/frame_info_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : frame_info_ctrl
// Brief    : Shadowed map/Kirby info words, committed atomically on vsync.
// Revision : 1.0  initial release
// ============================================================================
module frame_info_ctrl
    import frame_info_pkg::*;
#(
    parameter int FC_W = 16
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            VGA_VS,
    input  logic            wr_req,
    input  logic [1:0]      wr_addr,
    input  logic [31:0]     wr_data,
    output logic            wr_ack,
    output logic [31:0]     Map_Info,
    output logic [31:0]     Kirby_Info,
    output logic            commit_pending,
    output logic [FC_W-1:0] frame_count
);

    logic            w_vs_fall;
    logic            w_accept;
    logic            w_ctrl_wr;
    logic            w_arm;
    logic            w_cancel;

    state_t          r_state;
    logic            r_pending;
    logic            r_ack;
    logic [31:0]     r_map_sh;
    logic [31:0]     r_kirby_sh;
    logic [31:0]     r_map;
    logic [31:0]     r_kirby;
    logic [FC_W-1:0] r_fc;

    vs_edge_sync u_vs_sync (
        .Clk       (Clk),
        .Reset     (Reset),
        .i_vs_n    (VGA_VS),
        .o_vs_fall (w_vs_fall)
    );

    assign w_accept  = wr_req && !r_ack && (r_state != ST_COMMIT);
    assign w_ctrl_wr = w_accept && (wr_addr == ADDR_CTRL);
    assign w_arm     = w_ctrl_wr && wr_data[CTRL_ARM_BIT];
    assign w_cancel  = w_ctrl_wr && !wr_data[CTRL_ARM_BIT] && wr_data[CTRL_CANCEL_BIT];

    // A cancel arriving with vs_fall wins: the CPU asked to drop the commit.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state   <= ST_IDLE;
            r_pending <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_arm) begin
                        r_state   <= ST_ARMED;
                        r_pending <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (w_cancel) begin
                        r_state   <= ST_IDLE;
                        r_pending <= 1'b0;
                    end else if (w_vs_fall) begin
                        r_state   <= ST_COMMIT;
                        r_pending <= 1'b0;
                    end
                end
                ST_COMMIT: begin
                    r_state   <= ST_IDLE;
                    r_pending <= 1'b0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_pending <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_ack      <= 1'b0;
            r_map_sh   <= '0;
            r_kirby_sh <= '0;
            r_map      <= '0;
            r_kirby    <= '0;
            r_fc       <= '0;
        end else begin
            r_ack <= w_accept;
            if (w_accept) begin
                case (wr_addr)
                    ADDR_MAP:   r_map_sh   <= wr_data & MAP_WORD_MASK;
                    ADDR_KIRBY: r_kirby_sh <= wr_data;
                    default:    ;
                endcase
            end
            // Shadows are frozen in COMMIT because writes stall there.
            if (r_state == ST_COMMIT) begin
                r_map   <= r_map_sh;
                r_kirby <= r_kirby_sh;
            end
            if (w_vs_fall) begin
                r_fc <= r_fc + FC_W'(1);
            end
        end
    end

    assign wr_ack         = r_ack;
    assign Map_Info       = r_map;
    assign Kirby_Info     = r_kirby;
    assign commit_pending = r_pending;
    assign frame_count    = r_fc;

endmodule : frame_info_ctrl
`default_nettype wire

// File: tb/tb_frame_info_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_info_ctrl
// Brief    : Scoreboard bench for frame_info_ctrl (default and 4-bit counter).
// Revision : 1.0  initial release
// ============================================================================
module tb_frame_info_ctrl;
    import frame_info_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        VGA_VS;
    logic        wr_req;
    logic [1:0]  wr_addr;
    logic [31:0] wr_data;

    logic        wr_ack,  wr_ack4;
    logic [31:0] Map_Info, Map_Info4;
    logic [31:0] Kirby_Info, Kirby_Info4;
    logic        commit_pending, commit_pending4;
    logic [15:0] frame_count;
    logic [3:0]  frame_count4;

    always #10 Clk = ~Clk;

    frame_info_ctrl u_dut (
        .Clk(Clk), .Reset(Reset), .VGA_VS(VGA_VS),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack), .Map_Info(Map_Info), .Kirby_Info(Kirby_Info),
        .commit_pending(commit_pending), .frame_count(frame_count)
    );

    frame_info_ctrl #(.FC_W(4)) u_dut4 (
        .Clk(Clk), .Reset(Reset), .VGA_VS(VGA_VS),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack4), .Map_Info(Map_Info4), .Kirby_Info(Kirby_Info4),
        .commit_pending(commit_pending4), .frame_count(frame_count4)
    );

    typedef struct packed {
        logic [31:0] map;
        logic [31:0] kirby;
    } out_t;

    int          checks = 0;
    int          errors = 0;
    out_t        q_out[$];
    logic [31:0] m_map_sh;
    logic [31:0] m_kirby_sh;
    bit          m_armed;
    int          m_fc;
    logic [31:0] prev_map;
    logic [31:0] prev_kirby;

    // Every visible output change must match the oldest expected commit.
    always @(negedge Clk) begin
        out_t e;
        if (!Reset) begin
            prev_map   = Map_Info;
            prev_kirby = Kirby_Info;
        end else if (Map_Info !== prev_map || Kirby_Info !== prev_kirby) begin
            checks++;
            if (q_out.size() == 0) begin
                errors++;
                $display("FAIL out_change: Map_Info=%h Kirby_Info=%h changed, required unchanged %h %h",
                         Map_Info, Kirby_Info, prev_map, prev_kirby);
            end else begin
                e = q_out.pop_front();
                if (Map_Info !== e.map || Kirby_Info !== e.kirby) begin
                    errors++;
                    $display("FAIL commit_value: Map_Info=%h Kirby_Info=%h, required %h %h",
                             Map_Info, Kirby_Info, e.map, e.kirby);
                end
            end
            prev_map   = Map_Info;
            prev_kirby = Kirby_Info;
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation still running, required to finish");
        $fatal(1, "timeout");
    end

    task automatic model_clear();
        m_map_sh   = '0;
        m_kirby_sh = '0;
        m_armed    = 1'b0;
        m_fc       = 0;
        q_out.delete();
    endtask

    task automatic apply_reset();
        @(negedge Clk);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        model_clear();
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d, output int lat);
        wr_addr = a;
        wr_data = d;
        wr_req  = 1'b1;
        lat     = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            lat++;
            if (wr_ack) break;
        end
        wr_req = 1'b0;
        checks++;
        if (wr_ack !== 1'b1) begin
            errors++;
            $display("FAIL ack_timeout: wr_ack=%b after %0d cycles, required 1", wr_ack, lat);
        end else begin
            case (a)
                ADDR_MAP:   m_map_sh   = d & 32'h0003_FFFF;
                ADDR_KIRBY: m_kirby_sh = d;
                ADDR_CTRL: begin
                    if (d[0])      m_armed = 1'b1;
                    else if (d[1]) m_armed = 1'b0;
                end
                default: ;
            endcase
        end
        @(negedge Clk);
        checks++;
        if (wr_ack !== 1'b0) begin
            errors++;
            $display("FAIL ack_single: wr_ack=%b one cycle later, required 0", wr_ack);
        end
    endtask

    task automatic vs_pulse();
        VGA_VS = 1'b0;
        m_fc++;
        if (m_armed) begin
            q_out.push_back({m_map_sh, m_kirby_sh});
            m_armed = 1'b0;
        end
        repeat (6) @(negedge Clk);
        VGA_VS = 1'b1;
        repeat (6) @(negedge Clk);
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic check_fc(input string name);
        checks++;
        if (frame_count !== 16'(m_fc) || frame_count4 !== 4'(m_fc)) begin
            errors++;
            $display("FAIL %s: frame_count=%0d frame_count4=%0d, required %0d %0d",
                     name, frame_count, frame_count4, 16'(m_fc), 4'(m_fc));
        end
    endtask

    task automatic check_q_empty(input string name);
        checks++;
        if (q_out.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected commits not seen, required 0", name, q_out.size());
        end
        q_out.delete();
    endtask

    task automatic test_reset();
        check_val("rst_map",     Map_Info,   32'h0);
        check_val("rst_kirby",   Kirby_Info, 32'h0);
        check_val("rst_ack",     {31'h0, wr_ack}, 32'h0);
        check_val("rst_pending", {31'h0, commit_pending}, 32'h0);
        check_val("rst_dut4",    Map_Info4 | Kirby_Info4 | {31'h0, wr_ack4 | commit_pending4}, 32'h0);
        check_fc("rst_fc");
    endtask

    task automatic test_map_commit();
        int lat;
        do_write(ADDR_MAP, 32'hFFFF_1234, lat);
        check_val("map_wr_lat", 32'(lat), 32'd1);
        do_write(ADDR_CTRL, 32'h1, lat);
        check_val("map_pending_armed", {31'h0, commit_pending}, 32'h1);
        vs_pulse();
        check_val("map_committed", Map_Info, 32'h0003_1234);
        check_val("map_pending_done", {31'h0, commit_pending}, 32'h0);
        check_fc("map_fc");
        check_q_empty("map_commit_seen");
    endtask

    task automatic test_no_arm();
        int lat;
        apply_reset();
        do_write(ADDR_KIRBY, 32'h1020_3040, lat);
        repeat (3) vs_pulse();
        check_val("noarm_kirby", Kirby_Info, 32'h0);
        check_val("noarm_fc3", {16'h0, frame_count}, 32'd3);
        check_fc("noarm_fc");
    endtask

    task automatic test_cancel();
        int lat;
        do_write(ADDR_CTRL, 32'h1, lat);
        check_val("cancel_pending1", {31'h0, commit_pending}, 32'h1);
        do_write(ADDR_CTRL, 32'h2, lat);
        check_val("cancel_pending0", {31'h0, commit_pending}, 32'h0);
        vs_pulse();
        check_val("cancel_kirby", Kirby_Info, 32'h0);
        check_q_empty("cancel_no_commit");
    endtask

    task automatic test_arm_same_vs();
        int lat;
        VGA_VS = 1'b0;
        m_fc++;
        repeat (3) @(negedge Clk);
        do_write(ADDR_CTRL, 32'h1, lat);
        VGA_VS = 1'b1;
        repeat (6) @(negedge Clk);
        check_val("samevs_still_armed", {31'h0, commit_pending}, 32'h1);
        check_val("samevs_kirby_hold", Kirby_Info, 32'h0);
        vs_pulse();
        check_val("samevs_next_commit", Kirby_Info, 32'h1020_3040);
        check_fc("samevs_fc");
        check_q_empty("samevs_commit_seen");
    endtask

    task automatic test_stall_commit();
        int lat;
        do_write(ADDR_MAP, 32'h0001_AABB, lat);
        do_write(ADDR_CTRL, 32'h1, lat);
        VGA_VS = 1'b0;
        m_fc++;
        q_out.push_back({m_map_sh, m_kirby_sh});
        m_armed = 1'b0;
        repeat (4) @(negedge Clk);
        do_write(ADDR_MAP, 32'h0002_CCDD, lat);
        check_val("stall_lat", 32'(lat), 32'd2);
        VGA_VS = 1'b1;
        repeat (6) @(negedge Clk);
        check_val("stall_map_old", Map_Info, 32'h0001_AABB);
        check_q_empty("stall_commit_seen");
        do_write(ADDR_CTRL, 32'h1, lat);
        vs_pulse();
        check_val("stall_map_new", Map_Info, 32'h0002_CCDD);
        check_q_empty("stall_commit2_seen");
    endtask

    task automatic test_latest_shadow();
        int lat;
        do_write(ADDR_RSVD, 32'h1, lat);
        check_val("rsvd_no_arm", {31'h0, commit_pending}, 32'h0);
        do_write(ADDR_CTRL, 32'h1, lat);
        do_write(ADDR_CTRL, 32'h1, lat);
        check_val("rearm_pending", {31'h0, commit_pending}, 32'h1);
        do_write(ADDR_KIRBY, 32'hA1A2_A3A4, lat);
        do_write(ADDR_KIRBY, 32'hB1B2_B3B4, lat);
        do_write(ADDR_RSVD, 32'hFFFF_FFFF, lat);
        check_val("rsvd_keeps_armed", {31'h0, commit_pending}, 32'h1);
        vs_pulse();
        check_val("latest_kirby", Kirby_Info, 32'hB1B2_B3B4);
        check_val("latest_map", Map_Info, 32'h0002_CCDD);
        check_q_empty("latest_commit_seen");
    endtask

    task automatic test_reset_armed();
        int lat;
        do_write(ADDR_KIRBY, 32'h5555_0000, lat);
        do_write(ADDR_CTRL, 32'h1, lat);
        apply_reset();
        check_val("rarm_map", Map_Info, 32'h0);
        check_val("rarm_kirby", Kirby_Info, 32'h0);
        check_val("rarm_pending", {31'h0, commit_pending}, 32'h0);
        check_fc("rarm_fc");
        vs_pulse();
        check_val("rarm_idle_kirby", Kirby_Info, 32'h0);
        check_q_empty("rarm_no_commit");
    endtask

    task automatic test_fc_wrap();
        apply_reset();
        repeat (17) vs_pulse();
        check_val("wrap_fc4", {28'h0, frame_count4}, 32'd1);
        check_fc("wrap_fc");
    endtask

    initial begin
        Reset   = 1'b0;
        VGA_VS  = 1'b1;
        wr_req  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        model_clear();
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        test_reset();
        test_map_commit();
        test_no_arm();
        test_cancel();
        test_arm_same_vs();
        test_stall_commit();
        test_latest_shadow();
        test_reset_armed();
        test_fc_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_frame_info_ctrl
`default_nettype wire
